// File: rtl/cla_pkg.sv
// Shared definitions for the digit-serial carry-look-ahead adder.
//   SLICE_W  : bits handled per digit cycle
//   state_t  : sequencing FSM states
//   nslice() : number of digit cycles for a given operand width
package cla_pkg;

  localparam int SLICE_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/cla_slice3.sv
// Combinational 3-bit carry-look-ahead slice.
//   x, y : operand digits
//   ci   : carry in
//   s    : digit sum
//   co   : carry out
// Every carry is formed directly from generate/propagate terms, so the
// slice has no rippling carry chain.
module cla_slice3 (
  input  logic [2:0] x,
  input  logic [2:0] y,
  input  logic       ci,
  output logic [2:0] s,
  output logic       co
);

  logic [2:0] g;
  logic [2:0] p;
  logic       c1;
  logic       c2;

  assign g = x & y;
  assign p = x ^ y;

  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign co = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c2, c1, ci};

endmodule

// File: rtl/cla_serial_adder.sv
// Digit-serial wide adder: {cout,sum} = a + b + cin, one 3-bit digit per
// clock, least significant digit first, through a single CLA slice.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : operand handshake (a, b, cin)
//   out_valid / out_ready: result handshake (sum, cout)
//   busy                 : operation in flight or result waiting
//
// state | meaning
// IDLE  | waiting for operands; last result still on sum/cout
// RUN   | one digit per cycle through the slice, idx selects the digit
// DONE  | result valid, held until out_ready
module cla_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSLICE = nslice(WIDTH);
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
    $error("cla_serial_adder: WIDTH must be a positive multiple of 3");
  end

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic [SLICE_W-1:0] x_dig;
  logic [SLICE_W-1:0] y_dig;
  logic [SLICE_W-1:0] s_dig;
  logic               co_dig;
  logic               last_dig;

  assign last_dig = (idx_q == IDX_W'(NSLICE - 1));

  always_comb begin
    x_dig = '0;
    y_dig = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IDX_W'(i)) begin
        x_dig = a_q[i*SLICE_W +: SLICE_W];
        y_dig = b_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  cla_slice3 u_slice (
    .x  (x_dig),
    .y  (y_dig),
    .ci (carry_q),
    .s  (s_dig),
    .co (co_dig)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_dig) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands are only sampled on an accepted handshake, so undriven inputs
  // outside IDLE never reach the datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) sum_q[i*SLICE_W +: SLICE_W] <= s_dig;
          end
          carry_q <= co_dig;
          if (last_dig) cout_q <= co_dig;
          else          idx_q  <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
